snes_serializer: RTL and testbench

//  Downstream of the button recoder: converts the registered 12-bit active-low SNES

---
 rtl/snes_pkg.sv | 17 +
 rtl/snes_pin_sync.sv | 49 ++++
 rtl/snes_serializer.sv | 162 ++++++++++++++++
 tb/tb_snes_serializer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_pkg.sv
// snes_pkg: shared types and constants for the SNES controller serializer.
//   snes_ser_state_t : serializer FSM states (IDLE, LOAD, SHIFT, DONE)
//   SNES_FRAME_BITS  : bits in one controller frame
//   SNES_BTN_BITS    : real button bits at the bottom of the frame
package snes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } snes_ser_state_t;

  localparam int unsigned SNES_FRAME_BITS = 16;
  localparam int unsigned SNES_BTN_BITS   = 12;

endpackage

// File: rtl/snes_pin_sync.sv
// snes_pin_sync: brings one asynchronous console pin into the clk domain and
// produces registered one-cycle edge pulses.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset; all flops load RESET_VAL (edges 0)
//   pin_i   : raw asynchronous pin
//   level_o : synchronized level, aligned with the edge pulses
//   rise_o  : one-cycle pulse after a 0->1 transition
//   fall_o  : one-cycle pulse after a 1->0 transition
// Pin edge to pulse visible: SYNC_STAGES+1 clk.
module snes_pin_sync
  import snes_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  always_comb begin
    level_o = prev_q;
    rise_o  = rise_q;
    fall_o  = fall_q;
  end

endmodule

// File: rtl/snes_serializer.sv
// snes_serializer: emulates the controller-side 4021 shift registers. A latch
// pulse from the console captures the active-low button vector into a frame
// (upper bits padded with 1), and each console clock rising edge shifts the
// next frame bit onto DATA. After the last bit DATA is held low.
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   buttons_n  : active-low buttons, bit0 = B ... bit11 = R
//   snes_latch : console LATCH pin (async, active-high pulse)
//   snes_clock : console CLOCK pin (async, idles high)
//   snes_data  : serial DATA to console (registered)
//   busy       : high while loading or shifting a frame
//   frame_done : one-cycle pulse when the final frame bit has been shifted out
module snes_serializer
  import snes_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned BTN_BITS       = SNES_BTN_BITS,
  parameter int unsigned FRAME_BITS     = SNES_FRAME_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 24000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BTN_BITS-1:0] buttons_n,
  input  logic                snes_latch,
  input  logic                snes_clock,
  output logic                snes_data,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_lvl, clk_rise, clk_fall;
  logic unused_pin_info;

  snes_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_latch_sync (
    .clk_i   (clk),
    .rst_i   (reset),
    .pin_i   (snes_latch),
    .level_o (latch_lvl),
    .rise_o  (latch_rise),
    .fall_o  (latch_fall)
  );

  // Clock pin idles high, so its synchronizer resets high to avoid a false
  // rising edge right after reset release.
  snes_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_clock_sync (
    .clk_i   (clk),
    .rst_i   (reset),
    .pin_i   (snes_clock),
    .level_o (clk_lvl),
    .rise_o  (clk_rise),
    .fall_o  (clk_fall)
  );

  always_comb unused_pin_info = latch_lvl ^ clk_lvl ^ clk_fall;

  snes_ser_state_t       state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [FRAME_BITS-1:0] load_vec;

  always_comb load_vec = {{(FRAME_BITS-BTN_BITS){1'b1}}, buttons_n};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      data_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    data_d    = data_q;
    done_d    = 1'b0;

    // A new latch restarts the frame from any state and outranks any
    // same-cycle clock edge or timeout.
    if (latch_rise) begin
      state_d   = LOAD;
      shift_d   = load_vec;
      data_d    = buttons_n[0];
      bit_cnt_d = '0;
      to_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: data_d = 1'b1;
        LOAD: begin
          // Transparent while latch is high: follow the live buttons.
          shift_d = load_vec;
          data_d  = buttons_n[0];
          if (latch_fall) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            shift_d   = {1'b0, shift_q[FRAME_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            to_cnt_d  = '0;
            if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
              data_d  = 1'b0;
            end else begin
              data_d = shift_q[1];
            end
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            data_d  = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        DONE:    data_d = 1'b0;
        default: begin
          state_d = IDLE;
          data_d  = 1'b1;
        end
      endcase
    end

    busy_d = (state_d == LOAD) || (state_d == SHIFT);
  end

  always_comb begin
    snes_data  = data_q;
    busy       = busy_q;
    frame_done = done_q;
  end

endmodule

// File: tb/tb_snes_serializer.sv
module tb_snes_serializer;

  localparam int unsigned NS = 2;
  localparam int unsigned BB = 12;
  localparam int unsigned FB = 16;
  localparam int unsigned TO = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BB-1:0] buttons_n = '1;
  logic          snes_latch = 1'b0;
  logic          snes_clock = 1'b1;
  logic          snes_data, busy, frame_done;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned done_cnt = 0;

  snes_serializer #(
    .SYNC_STAGES    (NS),
    .BTN_BITS       (BB),
    .FRAME_BITS     (FB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons_n  (buttons_n),
    .snes_latch (snes_latch),
    .snes_clock (snes_clock),
    .snes_data  (snes_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin samples are delayed through a history window: an edge seen between
  // samples k-2-NS and k-1-NS takes effect at clk edge k.
  typedef enum int {M_IDLE, M_LOAD, M_SHIFT, M_DONE} mmode_t;
  mmode_t        m_mode;
  logic          lh [NS+2];
  logic          ch [NS+2];
  logic [FB-1:0] m_frame;
  int unsigned   m_pos;
  longint        cyc = 0;
  longint        last_act = 0;
  logic          e_data, e_busy, e_done;
  bit            model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_IDLE;
      m_pos  = 0;
      e_data = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
      for (int i = 0; i < NS + 2; i++) begin
        lh[i] = 1'b0;
        ch[i] = 1'b1;
      end
      model_valid = 1'b1;
    end else begin
      logic lr, lf, cr;
      lr = lh[1] & ~lh[0];
      lf = ~lh[1] & lh[0];
      cr = ch[1] & ~ch[0];
      e_done = 1'b0;
      if (lr) begin
        m_mode = M_LOAD;
      end else begin
        case (m_mode)
          M_LOAD: if (lf) begin
            for (int i = 0; i < FB; i++) m_frame[i] = (i < BB) ? buttons_n[i] : 1'b1;
            m_pos    = 0;
            m_mode   = M_SHIFT;
            last_act = cyc;
          end
          M_SHIFT: if (cr) begin
            if (m_pos == FB - 1) begin
              m_mode = M_DONE;
              e_done = 1'b1;
            end else begin
              m_pos++;
            end
            last_act = cyc;
          end else if (cyc - last_act == longint'(TO)) begin
            m_mode = M_IDLE;
          end
          default: ;
        endcase
      end
      case (m_mode)
        M_IDLE:  e_data = 1'b1;
        M_LOAD:  e_data = buttons_n[0];
        M_SHIFT: e_data = m_frame[m_pos];
        default: e_data = 1'b0;
      endcase
      e_busy = (m_mode == M_LOAD) || (m_mode == M_SHIFT);
      for (int i = 0; i < NS + 1; i++) begin
        lh[i] = lh[i+1];
        ch[i] = ch[i+1];
      end
      lh[NS+1] = snes_latch;
      ch[NS+1] = snes_clock;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!reset && model_valid) begin
      chk("cyc_data", snes_data, e_data);
      chk("cyc_busy", busy, e_busy);
      chk("cyc_done", frame_done, e_done);
      if (frame_done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic latch_pulse(input int unsigned hi);
    snes_latch = 1'b1;
    step(hi);
    snes_latch = 1'b0;
    step(NS + 3);
  endtask

  task automatic clk_pulse(input int unsigned lo, input int unsigned hi);
    snes_clock = 1'b0;
    step(lo);
    snes_clock = 1'b1;
    step(hi);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic [15:0] exp3;
    logic [15:0] exp4;
    int unsigned d0;

    step(3);
    chk("rst_data", snes_data, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    reset = 1'b0;
    step(4);

    // 1: B pressed, full frame
    exp1 = 16'hFFFE;
    buttons_n = 12'hFFE;
    d0 = done_cnt;
    latch_pulse(3);
    chk("t1_bit0", snes_data, exp1[0]);
    chk("t1_busy", busy, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      clk_pulse(2, 6);
      chk($sformatf("t1_bit%0d", i), snes_data, (i < 16) ? exp1[i] : 1'b0);
    end
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_busy_end", busy, 1'b0);
    clk_pulse(2, 6);
    chk("t1_extra_clk", snes_data, 1'b0);

    // 2: all pressed; busy through LOAD and SHIFT
    exp2 = 16'hF000;
    buttons_n = 12'h000;
    snes_latch = 1'b1;
    step(6);
    chk("t2_load_busy", busy, 1'b1);
    chk("t2_load_data", snes_data, 1'b0);
    snes_latch = 1'b0;
    step(NS + 3);
    for (int i = 1; i <= 15; i++) begin
      clk_pulse(2, 6);
      chk($sformatf("t2_bit%0d", i), snes_data, exp2[i]);
      chk($sformatf("t2_busy%0d", i), busy, 1'b1);
    end
    clk_pulse(2, 6);
    chk("t2_after", snes_data, 1'b0);

    // 3: stall after 5 clocks -> timeout
    exp3 = 16'hF0F0;
    buttons_n = 12'h0F0;
    d0 = done_cnt;
    latch_pulse(3);
    for (int i = 1; i <= 5; i++) clk_pulse(2, 6);
    chk("t3_bit5", snes_data, exp3[5]);
    step(TO + 20);
    chk("t3_data", snes_data, 1'b1);
    chk("t3_busy", busy, 1'b0);
    chk("t3_done_count", done_cnt - d0, 0);

    // 4: relatch after 7 clocks
    buttons_n = 12'hFFE;
    latch_pulse(3);
    for (int i = 1; i <= 7; i++) clk_pulse(2, 6);
    chk("t4_bit7", snes_data, 1'b1);
    exp4 = 16'hFA5A;
    buttons_n = 12'hA5A;
    d0 = done_cnt;
    latch_pulse(3);
    chk("t4_reload", snes_data, exp4[0]);
    for (int i = 1; i <= 16; i++) begin
      clk_pulse(2, 6);
      chk($sformatf("t4_bit%0d", i), snes_data, (i < 16) ? exp4[i] : 1'b0);
    end
    chk("t4_done_count", done_cnt - d0, 1);

    // 5: buttons change mid-shift
    buttons_n = 12'hFFE;
    latch_pulse(3);
    for (int i = 1; i <= 16; i++) begin
      if (i == 4) buttons_n = 12'hFFD;
      clk_pulse(2, 6);
      chk($sformatf("t5_bit%0d", i), snes_data, (i < 16) ? exp1[i] : 1'b0);
    end

    // 6: async reset mid-shift
    buttons_n = 12'h000;
    latch_pulse(3);
    for (int i = 1; i <= 4; i++) clk_pulse(2, 6);
    snes_clock = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    snes_clock = 1'b1;
    step(2);
    reset = 1'b0;
    step(NS + 4);
    chk("t6_data", snes_data, 1'b1);
    chk("t6_busy", busy, 1'b0);
    clk_pulse(2, 6);
    chk("t6_noshift", snes_data, 1'b1);

    // randomized frames against the model
    for (int n = 0; n < 60; n++) begin
      int unsigned kind, nclk;
      buttons_n = BB'($urandom);
      kind = $urandom_range(0, 9);
      nclk = (kind < 6) ? 16 + $urandom_range(0, 3) : $urandom_range(0, 15);
      latch_pulse($urandom_range(1, 4));
      for (int i = 0; i < int'(nclk); i++) begin
        if ($urandom_range(0, 3) == 0) buttons_n = BB'($urandom);
        snes_clock = 1'b0;
        step($urandom_range(1, 4));
        snes_clock = 1'b1;
        if (kind == 7 && i == 5) snes_latch = 1'b1;
        step($urandom_range(1, 4));
        snes_latch = 1'b0;
      end
      if (kind == 8) begin
        step(TO - 10 + $urandom_range(0, 20));
      end else if (kind == 9) begin
        reset = 1'b1;
        step(2);
        snes_clock = 1'b1;
        reset = 1'b0;
        step(NS + 2);
      end else begin
        step($urandom_range(0, 8));
      end
    end

    step(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
